per_mux_arb: RTL and testbench
==============================

Name: per_mux_arb

Overview:
- N-to-1 arbiter/mux on the XBAR_TCDM_BUS peripheral protocol (req/add/we_n/wdata/be/gnt/r_valid/r_opc/r_rdata).
- Collects NB_SLAVES upstream initiator ports onto one downstream target port.
- Converging counterpart of the per-demux: round-robin request arbitration, plus in-order routing of responses back to the originating port through an outstanding-ID FIFO.

Parameters:
- NB_SLAVES, 2, number of upstream initiator ports; must be >=2.
- MAX_OUTSTANDING, 2, depth of the in-flight ID FIFO; must be >=1.
- ID_W, $clog2(NB_SLAVES), width of the port index (derived, localparam).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- s_req_i  input  NB_SLAVES  per-port request.
- s_add_i  input  NB_SLAVES x 32  per-port address.
- s_we_n_i  input  NB_SLAVES  per-port write-enable, active-low (1 = read).
- s_wdata_i  input  NB_SLAVES x 32  per-port write data.
- s_be_i  input  NB_SLAVES x 4  per-port byte enables.
- s_gnt_o  output  NB_SLAVES  per-port grant.
- s_r_valid_o  output  NB_SLAVES  per-port response valid.
- s_r_opc_o  output  NB_SLAVES  per-port response error flag.
- s_r_rdata_o  output  NB_SLAVES x 32  per-port read data.
- m_req_o  output  1  downstream request.
- m_add_o  output  32  downstream address.
- m_we_n_o  output  1  downstream write-enable, active-low.
- m_wdata_o  output  32  downstream write data.
- m_be_o  output  4  downstream byte enables.
- m_gnt_i  input  1  downstream grant.
- m_r_valid_i  input  1  downstream response valid.
- m_r_opc_i  input  1  downstream response error flag.
- m_r_rdata_i  input  32  downstream read data.
- err_o  output  1  sticky protocol error; present only with PER_MUX_ARB_ERR_EN.

Behaviour:
- Reset:
  - rr_ptr = 0; FIFO empty (wr_ptr = rd_ptr = 0, count = 0).
  - All s_gnt_o, s_r_valid_o, m_req_o = 0; err_o = 0.
  - Data outputs are don't-care in reset.
- Arbitration (combinational, same cycle):
  - Winner w = first asserted s_req_i[k] scanning k = rr_ptr, rr_ptr+1, ... modulo NB_SLAVES.
  - m_req_o = (|s_req_i) & ~full.
  - m_add_o, m_we_n_o, m_wdata_o and m_be_o carry port w's fields.
- Grant and handshake:
  - s_gnt_o[w] = m_gnt_i & m_req_o. All other grants are 0. Zero-cycle grant path, as on the target.
  - Handshake = m_req_o & m_gnt_i. On a handshake, push w into the FIFO and set rr_ptr <= (w+1) mod NB_SLAVES.
  - No handshake: rr_ptr holds. A denied requester keeps its priority.
- Full:
  - When count == MAX_OUTSTANDING and no pop occurs this cycle, m_req_o = 0 and no grant is issued.
  - Push is allowed at full when a pop occurs in the same cycle (full = count == MAX_OUTSTANDING & ~pop).
- Responses:
  - Strictly in order, latency >= 1 cycle after grant.
  - When m_r_valid_i = 1 and the FIFO is non-empty, route to head ID h: s_r_valid_o[h] = 1, with s_r_opc_o[h] and s_r_rdata_o[h] taken from the master port. Pop in the same cycle.
  - All other s_r_valid_o = 0. r_rdata/r_opc are broadcast to all ports; only the valid bit is steered.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- Spurious response: m_r_valid_i with the FIFO empty is dropped (no s_r_valid_o, no pop, count stays 0).
- Upstream contract: a requester holds req and its fields stable until granted. The block does not check this.
- Reset mid-operation: outstanding IDs are discarded. Responses arriving after reset deassertion follow the spurious-response rule.

Optional Feature:
- Macro: PER_MUX_ARB_ERR_EN.
- Defined:
  - err_o is present.
  - err_o sets on a spurious response (m_r_valid_i with FIFO empty).
  - err_o also sets on m_gnt_i asserted while m_req_o = 0.
  - err_o is sticky until reset.
  - Simulation assertions on the same two conditions are compiled in.
- Undefined: no err_o port, no error register, no assertions. All other behaviour is identical.

Test Plan:
- Single-port read: NB_SLAVES=4; s_req_i=4'b0100 with add 0x1A10_0004, m_gnt_i=1 -> m_add_o=0x1A10_0004 and s_gnt_o=4'b0100 in the same cycle; 1 cycle later, m_r_valid_i=1 with rdata 0xCAFE_0001 -> s_r_valid_o=4'b0100, s_r_rdata_o[2]=0xCAFE_0001.
- Round-robin fairness: s_req_i=4'b1111 held, m_gnt_i=1 for 4 cycles -> grant order ports 0,1,2,3; 5th grant is port 0.
- Grant stall: s_req_i=4'b0011, m_gnt_i=0 for 3 cycles then 1 -> no s_gnt_o while stalled; port 0 granted first, rr_ptr stays 0 during the stall.
- FIFO full: MAX_OUTSTANDING=2, two grants with no response -> m_req_o=0 on the 3rd request; a response arriving in that cycle enables push+pop and the 3rd grant in the same cycle.
- Out-of-order steering: grant port 3 then port 1; responses rdata 0x11, 0x22 -> 0x11 delivered on port 3 first, then 0x22 on port 1.
- Spurious response: with PER_MUX_ARB_ERR_EN defined, m_r_valid_i=1 with FIFO empty -> no s_r_valid_o and err_o=1, staying 1 until rst_ni=0.

Source files
------------

// File: rtl/per_mux_arb.sv
// N-to-1 round-robin arbiter for the XBAR_TCDM_BUS peripheral protocol.
// Responses return in order through an outstanding-ID FIFO. Define PER_MUX_ARB_ERR_EN for the sticky err_o.
`timescale 1ns/1ps
module per_mux_arb #(
  parameter int NB_SLAVES       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_SLAVES-1:0]    s_req_i,
  input  logic [NB_SLAVES*32-1:0] s_add_i,
  input  logic [NB_SLAVES-1:0]    s_we_n_i,
  input  logic [NB_SLAVES*32-1:0] s_wdata_i,
  input  logic [NB_SLAVES*4-1:0]  s_be_i,
  output logic [NB_SLAVES-1:0]    s_gnt_o,
  output logic [NB_SLAVES-1:0]    s_r_valid_o,
  output logic [NB_SLAVES-1:0]    s_r_opc_o,
  output logic [NB_SLAVES*32-1:0] s_r_rdata_o,
  output logic                    m_req_o,
  output logic [31:0]             m_add_o,
  output logic                    m_we_n_o,
  output logic [31:0]             m_wdata_o,
  output logic [3:0]              m_be_o,
  input  logic                    m_gnt_i,
  input  logic                    m_r_valid_i,
  input  logic                    m_r_opc_i,
  input  logic [31:0]             m_r_rdata_i
`ifdef PER_MUX_ARB_ERR_EN
  ,
  output logic                    err_o
`endif
);

  localparam int ID_W  = $clog2(NB_SLAVES);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  id_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ID_W-1:0]  win;
  logic             win_found;
  logic [ID_W-1:0]  head_id;
  logic             push;
  logic             pop;
  logic             full;

  assign pop     = m_r_valid_i & (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign full    = (count_q == CNT_W'(MAX_OUTSTANDING)) & ~pop;
  assign m_req_o = (|s_req_i) & ~full;
  assign push    = m_req_o & m_gnt_i;
  assign head_id = id_q[rd_ptr_q];

  always_comb begin
    logic [ID_W:0] sum;
    win       = rr_q;
    win_found = 1'b0;
    sum       = '0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NB_SLAVES)) begin
        sum = sum - (ID_W+1)'(NB_SLAVES);
      end
      if (!win_found && s_req_i[sum[ID_W-1:0]]) begin
        win       = sum[ID_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    m_add_o     = s_add_i[31:0];
    m_we_n_o    = s_we_n_i[0];
    m_wdata_o   = s_wdata_i[31:0];
    m_be_o      = s_be_i[3:0];
    s_gnt_o     = '0;
    s_r_valid_o = '0;
    for (int k = 0; k < NB_SLAVES; k++) begin
      if (ID_W'(k) == win) begin
        m_add_o    = s_add_i[k*32 +: 32];
        m_we_n_o   = s_we_n_i[k];
        m_wdata_o  = s_wdata_i[k*32 +: 32];
        m_be_o     = s_be_i[k*4 +: 4];
        s_gnt_o[k] = push;
      end
      s_r_valid_o[k] = pop & (ID_W'(k) == head_id);
    end
  end

  assign s_r_rdata_o = {NB_SLAVES{m_r_rdata_i}};
  assign s_r_opc_o   = {NB_SLAVES{m_r_opc_i}};

  always_comb begin
    rr_d     = rr_q;
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      id_d[wr_ptr_q] = win;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr_q + PTR_W'(1);
      rr_d     = (win == ID_W'(NB_SLAVES-1)) ? '0 : win + ID_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      id_q     <= id_d;
    end
  end

`ifdef PER_MUX_ARB_ERR_EN
  logic err_q, err_d;

  // Spurious response or a grant nobody asked for; held until reset.
  assign err_d = err_q | (m_r_valid_i & (count_q == '0)) | (m_gnt_i & ~m_req_o);
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  spurious_rsp_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m_r_valid_i && (count_q == '0)))
    else $warning("per_mux_arb: response with no outstanding id");

  unrequested_gnt_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m_gnt_i && !m_req_o))
    else $warning("per_mux_arb: grant while no request presented");
`endif

endmodule

// File: tb/tb_per_mux_arb.sv
// Scoreboard bench for per_mux_arb (4 ports, 2 outstanding): stimulus pushes expected
// grants/responses, a negedge monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_per_mux_arb;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [3:0]    s_req_i;
   logic [127:0]  s_add_i;
   logic [3:0]    s_we_n_i;
   logic [127:0]  s_wdata_i;
   logic [15:0]   s_be_i;
   logic [3:0]    s_gnt_o;
   logic [3:0]    s_r_valid_o;
   logic [3:0]    s_r_opc_o;
   logic [127:0]  s_r_rdata_o;
   logic          m_req_o;
   logic [31:0]   m_add_o;
   logic          m_we_n_o;
   logic [31:0]   m_wdata_o;
   logic [3:0]    m_be_o;
   logic          m_gnt_i;
   logic          m_r_valid_i;
   logic          m_r_opc_i;
   logic [31:0]   m_r_rdata_i;
`ifdef PER_MUX_ARB_ERR_EN
   logic          err_o;
`endif

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      int          port;
      logic [31:0] add;
      logic        weN;
      logic [31:0] wdata;
      logic [3:0]  be;
   } gntExp_t;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        opc;
   } rspExp_t;

   gntExp_t gntQueue[$];
   rspExp_t rspQueue[$];
   gntExp_t monGnt;
   rspExp_t monRsp;

   // 100 MHz free-running clock
   always #5 clk_i = ~clk_i;

   per_mux_arb #(
      .NB_SLAVES       (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .s_req_i     (s_req_i),
      .s_add_i     (s_add_i),
      .s_we_n_i    (s_we_n_i),
      .s_wdata_i   (s_wdata_i),
      .s_be_i      (s_be_i),
      .s_gnt_o     (s_gnt_o),
      .s_r_valid_o (s_r_valid_o),
      .s_r_opc_o   (s_r_opc_o),
      .s_r_rdata_o (s_r_rdata_o),
      .m_req_o     (m_req_o),
      .m_add_o     (m_add_o),
      .m_we_n_o    (m_we_n_o),
      .m_wdata_o   (m_wdata_o),
      .m_be_o      (m_be_o),
      .m_gnt_i     (m_gnt_i),
      .m_r_valid_i (m_r_valid_i),
      .m_r_opc_i   (m_r_opc_i),
      .m_r_rdata_i (m_r_rdata_i)
`ifdef PER_MUX_ARB_ERR_EN
      ,
      .err_o       (err_o)
`endif
   );

   // Every comparison funnels through here so the counters stay in one place
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives the upstream-request and downstream-response inputs for one cycle
   task automatic applyStimulus(input logic [3:0] req, input logic gnt, input logic rValid,
                                input logic [31:0] rData, input logic rOpc);
      s_req_i     = req;
      m_gnt_i     = gnt;
      m_r_valid_i = rValid;
      m_r_rdata_i = rData;
      m_r_opc_i   = rOpc;
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      nextCycle();
   endtask

   task automatic setPort(input int k, input logic [31:0] add, input logic weN,
                          input logic [31:0] wdata, input logic [3:0] be);
      s_add_i[k*32 +: 32]   = add;
      s_we_n_i[k]           = weN;
      s_wdata_i[k*32 +: 32] = wdata;
      s_be_i[k*4 +: 4]      = be;
   endtask

   // Expected downstream fields are the values this bench programmed for that port
   task automatic expectGrant(input int k);
      gntExp_t e;
      e.port  = k;
      e.add   = s_add_i[k*32 +: 32];
      e.weN   = s_we_n_i[k];
      e.wdata = s_wdata_i[k*32 +: 32];
      e.be    = s_be_i[k*4 +: 4];
      gntQueue.push_back(e);
   endtask

   task automatic expectResp(input int k, input logic [31:0] rdata, input logic opc);
      rspExp_t e;
      e.port  = k;
      e.rdata = rdata;
      e.opc   = opc;
      rspQueue.push_back(e);
   endtask

   task automatic drainCheck(input string name);
      checkOutput({name, "_grants_left"}, gntQueue.size(), 0);
      checkOutput({name, "_resps_left"}, rspQueue.size(), 0);
      gntQueue.delete();
      rspQueue.delete();
   endtask

   task automatic applyReset();
      rst_ni = 1'b0;
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      checkOutput("rst_s_gnt", s_gnt_o, 0);
      checkOutput("rst_s_r_valid", s_r_valid_o, 0);
      checkOutput("rst_m_req", m_req_o, 0);
`ifdef PER_MUX_ARB_ERR_EN
      checkOutput("rst_err", err_o, 0);
`endif
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   // Monitor: pops an expectation whenever the DUT presents a grant or a response
   always @(negedge clk_i) begin
      if (rst_ni === 1'b1) begin
         if (s_gnt_o !== 4'b0000) begin
            if (gntQueue.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected_grant: got s_gnt_o=0x%0h, expected none", s_gnt_o);
            end else begin
               monGnt = gntQueue.pop_front();
               checkOutput("gnt_vector", s_gnt_o, 4'(1) << monGnt.port);
               checkOutput("m_add", m_add_o, monGnt.add);
               checkOutput("m_we_n", m_we_n_o, monGnt.weN);
               checkOutput("m_wdata", m_wdata_o, monGnt.wdata);
               checkOutput("m_be", m_be_o, monGnt.be);
            end
         end
         if (s_r_valid_o !== 4'b0000) begin
            if (rspQueue.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected_resp: got s_r_valid_o=0x%0h, expected none", s_r_valid_o);
            end else begin
               monRsp = rspQueue.pop_front();
               checkOutput("r_valid_vector", s_r_valid_o, 4'(1) << monRsp.port);
               checkOutput("r_rdata", s_r_rdata_o[monRsp.port*32 +: 32], monRsp.rdata);
               checkOutput("r_opc", s_r_opc_o[monRsp.port], monRsp.opc);
            end
         end
      end
   end

   initial begin
      rst_ni    = 1'b0;
      s_add_i   = '0;
      s_we_n_i  = '1;
      s_wdata_i = '0;
      s_be_i    = '0;
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      applyReset();

      // Single-port read on port 2, response one cycle after the grant
      $display("[TB] single-port read");
      setPort(2, 32'h1A10_0004, 1'b1, 32'h0, 4'hF);
      applyStimulus(4'b0100, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(2);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
      expectResp(2, 32'hCAFE_0001, 1'b0);
      nextCycle();
      idleCycle();
      drainCheck("single");

      // All four requesting: grants rotate 0,1,2,3 then back to 0
      $display("[TB] round-robin fairness");
      applyReset();
      for (int k = 0; k < 4; k++) begin
         setPort(k, 32'h2000_0000 + 32'(k*4), 1'b0, 32'hD000_0000 + 32'(k), 4'(1 << k));
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 1'b1, (i > 0), 32'h100 + 32'(i) - 32'h1, 1'b0);
         expectGrant(i % 4);
         if (i > 0) begin
            expectResp((i - 1) % 4, 32'h100 + 32'(i) - 32'h1, 1'b0);
         end
         nextCycle();
      end
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h104, 1'b0);
      expectResp(0, 32'h104, 1'b0);
      nextCycle();
      idleCycle();
      drainCheck("rr");

      // Downstream stall: nothing granted, port 0 keeps priority
      $display("[TB] grant stall");
      applyReset();
      setPort(0, 32'h3000_0000, 1'b1, 32'h0, 4'hF);
      setPort(1, 32'h3000_0010, 1'b0, 32'h5555_AAAA, 4'h3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0011, 1'b0, 1'b0, 32'h0, 1'b0);
         #2;
         checkOutput("stall_s_gnt", s_gnt_o, 0);
         checkOutput("stall_m_req", m_req_o, 1);
         checkOutput("stall_m_add", m_add_o, 32'h3000_0000);
         nextCycle();
      end
      applyStimulus(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(0);
      nextCycle();
      applyStimulus(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(1);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h30, 1'b0);
      expectResp(0, 32'h30, 1'b0);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h31, 1'b1);
      expectResp(1, 32'h31, 1'b1);
      nextCycle();
      idleCycle();
      drainCheck("stall");

      // Two outstanding fills the FIFO; a same-cycle response lets the third through
      $display("[TB] fifo full");
      applyReset();
      setPort(0, 32'h4000_0000, 1'b1, 32'h0, 4'hF);
      setPort(1, 32'h4000_0004, 1'b0, 32'h0BAD_F00D, 4'h1);
      setPort(2, 32'h4000_0008, 1'b1, 32'h0, 4'h8);
      applyStimulus(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(0);
      nextCycle();
      applyStimulus(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(1);
      nextCycle();
      applyStimulus(4'b0100, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      checkOutput("full_m_req", m_req_o, 0);
      checkOutput("full_s_gnt", s_gnt_o, 0);
      nextCycle();
      applyStimulus(4'b0100, 1'b1, 1'b1, 32'h40, 1'b0);
      #2;
      checkOutput("full_pushpop_m_req", m_req_o, 1);
      expectGrant(2);
      expectResp(0, 32'h40, 1'b0);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h41, 1'b0);
      expectResp(1, 32'h41, 1'b0);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h42, 1'b0);
      expectResp(2, 32'h42, 1'b0);
      nextCycle();
      idleCycle();
      drainCheck("full");

      // Port 3 then port 1; responses must follow grant order
      $display("[TB] response steering");
      setPort(3, 32'h5000_000C, 1'b0, 32'h1234_5678, 4'hC);
      setPort(1, 32'h5000_0004, 1'b1, 32'h0, 4'hF);
      applyStimulus(4'b1000, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(3);
      nextCycle();
      applyStimulus(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(1);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h11, 1'b0);
      expectResp(3, 32'h11, 1'b0);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h22, 1'b1);
      expectResp(1, 32'h22, 1'b1);
      nextCycle();
      idleCycle();
      drainCheck("steer");

      // Response with nothing outstanding is dropped and must not disturb the FIFO
      $display("[TB] spurious response");
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0);
      #2;
      checkOutput("spur_r_valid", s_r_valid_o, 0);
      nextCycle();
      idleCycle();
`ifdef PER_MUX_ARB_ERR_EN
      checkOutput("spur_err_set", err_o, 1);
      idleCycle();
      idleCycle();
      checkOutput("spur_err_sticky", err_o, 1);
`endif
      setPort(0, 32'h6000_0000, 1'b1, 32'h0, 4'hF);
      applyStimulus(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
      expectGrant(0);
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'h55, 1'b0);
      expectResp(0, 32'h55, 1'b0);
      nextCycle();
      idleCycle();
      drainCheck("spur");
`ifdef PER_MUX_ARB_ERR_EN
      checkOutput("spur_err_before_reset", err_o, 1);
`endif
      applyReset();
      idleCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
